// File: rtl/note_pitch_detector_pkg.sv
// rtl/note_pitch_detector_pkg.sv - shared scale-note constants and types for the pitch detector
package note_pitch_detector_pkg;

  // Half-period constants shared with the oscillator side (clk cycles per half wave)
  localparam int PITCH_C  = 15289;
  localparam int PITCH_D  = 13621;
  localparam int PITCH_E  = 12135;
  localparam int PITCH_F  = 11454;
  localparam int PITCH_G  = 10204;
  localparam int PITCH_A  = 9091;
  localparam int PITCH_B  = 8099;
  localparam int PITCH_C2 = 7645;

  localparam int NUM_NOTES = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_TRACK = 2'd2
  } meter_state_e;

  // Nominal full period of a scale note: two half periods
  function automatic int nom_period(input logic [2:0] idx);
    case (idx)
      3'd0:    return 2 * PITCH_C;
      3'd1:    return 2 * PITCH_D;
      3'd2:    return 2 * PITCH_E;
      3'd3:    return 2 * PITCH_F;
      3'd4:    return 2 * PITCH_G;
      3'd5:    return 2 * PITCH_A;
      3'd6:    return 2 * PITCH_B;
      default: return 2 * PITCH_C2;
    endcase
  endfunction

endpackage

// File: rtl/note_pitch_detector_pitch_period_meter.sv
// rtl/note_pitch_detector_pitch_period_meter.sv - rising-to-rising period meter with timeout
module pitch_period_meter
  import note_pitch_detector_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 40000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             audio_in,
  output logic [CNT_W-1:0] meas,
  output logic             meas_fire,
  output logic             absent,
  output logic [CNT_W-1:0] period,
  output logic             period_strobe
);

  logic             s1_q, s2_q, s3_q;
  logic             s1_d, s2_d, s3_d;
  meter_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             strobe_q, strobe_d;
  logic             rise;

  assign rise          = s2_q & ~s3_q;
  assign period        = period_q;
  assign period_strobe = strobe_q;

  // Register stage: synchronizer chain, FSM state, counter and period output
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      strobe_q <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      strobe_q <= strobe_d;
    end
  end

  // Next state: the first edge only arms; later edges close a period; a stalled count times out
  always_comb begin
    s1_d      = audio_in;
    s2_d      = s1_q;
    s3_d      = s2_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    strobe_d  = 1'b0;
    meas      = cnt_q + CNT_W'(1);
    meas_fire = 1'b0;
    absent    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_ARMED;
          cnt_d   = '0;
        end
      end
      ST_ARMED, ST_TRACK: begin
        if (rise) begin
          period_d  = meas;
          strobe_d  = 1'b1;
          meas_fire = 1'b1;
          cnt_d     = '0;
          state_d   = ST_TRACK;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_d = ST_IDLE;
          absent  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/note_pitch_detector.sv
// rtl/note_pitch_detector.sv - identifies the playing scale note from a square-wave period
module note_pitch_detector
  import note_pitch_detector_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 40000,
  parameter int TOL        = 256,
  parameter int LOCK_COUNT = 4,
  // Right shift of the nominal table, for running the detector from a divided clock
  parameter int NOM_SHIFT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             audio_in,
  output logic [CNT_W-1:0] period,
  output logic             period_strobe,
  output logic [2:0]       note_idx,
  output logic             note_valid,
  output logic [7:0]       note_onehot
);

  localparam int DW    = CNT_W + 1;
  localparam int RUN_W = $clog2(LOCK_COUNT + 1);
  localparam logic signed [DW-1:0] TOL_S = DW'(TOL);

  logic [CNT_W-1:0]     meas;
  logic                 meas_fire;
  logic                 absent;
  logic                 hit;
  logic [2:0]           hit_idx;
  logic signed [DW-1:0] diff;
  logic signed [DW-1:0] nom_s;

  logic [2:0]       last_idx_q, last_idx_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             valid_q, valid_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       onehot_q, onehot_d;

  pitch_period_meter #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) u_meter (
    .clk          (clk),
    .rst          (rst),
    .audio_in     (audio_in),
    .meas         (meas),
    .meas_fire    (meas_fire),
    .absent       (absent),
    .period       (period),
    .period_strobe(period_strobe)
  );

  assign note_idx    = idx_q;
  assign note_valid  = valid_q;
  assign note_onehot = onehot_q;

  // Classify the period being closed; table gaps exceed 2*TOL so at most one note hits
  always_comb begin
    hit     = 1'b0;
    hit_idx = 3'd0;
    diff    = '0;
    nom_s   = '0;
    for (int i = 0; i < NUM_NOTES; i++) begin
      nom_s = DW'(nom_period(3'(i)) >>> NOM_SHIFT);
      diff  = $signed({1'b0, meas}) - nom_s;
      if (diff <= TOL_S && diff >= -TOL_S) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
      end
    end
  end

  // Lock tracking: a note is reported only after LOCK_COUNT matching periods in a row
  always_comb begin
    last_idx_d = last_idx_q;
    run_d      = run_q;
    valid_d    = valid_q;
    idx_d      = idx_q;
    onehot_d   = onehot_q;
    if (meas_fire) begin
      if (hit) begin
        if (hit_idx == last_idx_q) begin
          run_d = (run_q >= RUN_W'(LOCK_COUNT)) ? run_q : run_q + RUN_W'(1);
        end else begin
          last_idx_d = hit_idx;
          run_d      = RUN_W'(1);
        end
      end else begin
        run_d = '0;
      end
      valid_d  = (run_d == RUN_W'(LOCK_COUNT));
      idx_d    = last_idx_d;
      onehot_d = valid_d ? (8'b1 << last_idx_d) : 8'h00;
    end else if (absent) begin
      run_d    = '0;
      valid_d  = 1'b0;
      onehot_d = 8'h00;
    end
  end

  // Lock state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      last_idx_q <= 3'd0;
      run_q      <= '0;
      valid_q    <= 1'b0;
      idx_q      <= 3'd0;
      onehot_q   <= 8'h00;
    end else begin
      last_idx_q <= last_idx_d;
      run_q      <= run_d;
      valid_q    <= valid_d;
      idx_q      <= idx_d;
      onehot_q   <= onehot_d;
    end
  end

endmodule

// File: tb/tb_note_pitch_detector.sv
// tb/tb_note_pitch_detector.sv - directed scoreboard bench for note_pitch_detector
module tb_note_pitch_detector;

  localparam int CNT_W      = 16;
  localparam int TIMEOUT    = 625;
  localparam int TOL        = 4;
  localparam int LOCK_COUNT = 4;
  localparam int NOM_SHIFT  = 6;

  // Nominal periods after the >>6 table shift: C=477 D=425 E=379 F=357 G=318 A=284 B=253 C2=238

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             audio_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic             period_strobe;
  logic [2:0]       note_idx;
  logic             note_valid;
  logic [7:0]       note_onehot;

  typedef struct {
    int         per;
    bit         vld;
    logic [2:0] idx;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic [7:0] exp_oh;
  int total = 0;
  int passes = 0;
  bit chord_mode = 1'b0;
  int chord_strobes = 0;

  note_pitch_detector #(
    .CNT_W     (CNT_W),
    .TIMEOUT   (TIMEOUT),
    .TOL       (TOL),
    .LOCK_COUNT(LOCK_COUNT),
    .NOM_SHIFT (NOM_SHIFT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .audio_in     (audio_in),
    .period       (period),
    .period_strobe(period_strobe),
    .note_idx     (note_idx),
    .note_valid   (note_valid),
    .note_onehot  (note_onehot)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One square-wave period of n cycles starting with a rise; optionally queue its expected report
  task automatic wave(input int n, input bit push, input bit vld, input logic [2:0] idx);
    exp_t x;
    if (push) begin
      x.per = n;
      x.vld = vld;
      x.idx = idx;
      sb.push_back(x);
    end
    audio_in = 1'b1;
    repeat (n / 2) @(negedge clk);
    audio_in = 1'b0;
    repeat (n - n / 2) @(negedge clk);
  endtask

  // Scoreboard side: every strobe must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && period_strobe === 1'b1) begin
      if (chord_mode) begin
        chord_strobes++;
        check("chord_valid", note_valid, 0);
        check("chord_onehot", note_onehot, 0);
        check("chord_no_x", $isunknown({period, note_idx, note_valid, note_onehot}), 0);
      end else begin
        check("strobe_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          exp_oh = e.vld ? (8'b1 << e.idx) : 8'h00;
          check("period", period, e.per);
          check("note_valid", note_valid, e.vld);
          check("note_onehot", note_onehot, exp_oh);
          if (e.vld) check("note_idx", note_idx, e.idx);
        end
      end
    end
  end

  initial begin
    int n;
    bit found;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_period", period, 0);
    check("rst_strobe", period_strobe, 0);
    check("rst_valid", note_valid, 0);
    check("rst_idx", note_idx, 0);
    check("rst_onehot", note_onehot, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single pitch G: the first rise only arms, lock on the 4th reported period
    for (int k = 0; k < 6; k++) wave(318, 1'b1, k >= 3, 3'd4);

    // Switch C -> C2: lock on C, the first C2 period drops it, 4th C2 period relocks
    for (int k = 0; k < 5; k++) wave(477, 1'b1, k >= 3, 3'd0);
    for (int k = 0; k < 4; k++) wave(238, 1'b1, k == 3, 3'd7);

    // Tolerance: A+4 locks, A+5 never hits, off-table never valid, A-4 locks
    for (int k = 0; k < 4; k++) wave(288, 1'b1, k == 3, 3'd5);
    for (int k = 0; k < 4; k++) wave(289, 1'b1, 1'b0, 3'd5);
    for (int k = 0; k < 3; k++) wave(400, 1'b1, 1'b0, 3'd0);
    for (int k = 0; k < 4; k++) wave(280, 1'b1, k == 3, 3'd5);

    // Latency and timeout: rise -> strobe in 3 clocks, then hold low until the lock is lost
    audio_in = 1'b1;
    found = 1'b0;
    n = 0;
    for (int i = 1; i <= 10 && !found; i++) begin
      @(negedge clk);
      if (period_strobe === 1'b1) begin
        found = 1'b1;
        n = i;
      end
    end
    check("strobe_latency", n, 3);
    check("locked_before_timeout", note_valid, 1);
    n = 0;
    while (note_valid === 1'b1 && n < TIMEOUT + 20) begin
      @(negedge clk);
      n++;
      if (n == 140) audio_in = 1'b0;
    end
    check("timeout_cycles", n, TIMEOUT + 1);
    check("timeout_onehot", note_onehot, 0);
    check("timeout_period_hold", period, 280);

    // After timeout the next rise only arms; an edge on the timeout cycle reports TIMEOUT+1
    wave(TIMEOUT + 1, 1'b1, 1'b0, 3'd0);
    wave(300, 1'b1, 1'b0, 3'd0);

    // Reset mid-lock
    for (int k = 0; k < 4; k++) wave(318, 1'b1, k == 3, 3'd4);
    wave(318, 1'b0, 1'b0, 3'd0);
    check("pre_reset_locked", note_valid, 1);
    check("pre_reset_sb_empty", sb.size(), 0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", note_valid, 0);
    check("midrst_onehot", note_onehot, 0);
    check("midrst_period", period, 0);
    check("midrst_idx", note_idx, 0);
    rst = 1'b0;
    wave(318, 1'b1, 1'b0, 3'd0);
    wave(318, 1'b0, 1'b0, 3'd0);
    check("post_rst_sb_empty", sb.size(), 0);

    // OR of C and E square waves: irregular periods, never a lock
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chord_mode = 1'b1;
    for (int t = 0; t < 26000; t++) begin
      audio_in = ((t % 477) < 239) | ((t % 379) < 190);
      @(negedge clk);
    end
    check("chord_strobe_count", chord_strobes >= 50, 1);
    check("final_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
